// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter: FSM states, parity modes, line levels.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // Even parity is the plain XOR; odd parity is its complement.
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (mode == PAR_ODD) ? ~(^d) : (^d);
    endfunction

endpackage

// File: rtl/serial_tx_baud_gen.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
module baud_gen #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int             CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  TC = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick = (cnt_q == TC);
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//
// state | meaning
// IDLE  | line high, status high, waiting for an armed start request
// START | driving the start bit (low) for one bit time
// DATA  | shifting out data bits 0..7
// PAR   | driving the parity bit (only when PARITY is not none)
// STOP  | driving the stop level for STOP_BITS bit times
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       cereal,
    output logic       status
);

    state_t     state_q,   state_d;
    logic [7:0] shift_q,   shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       par_q,     par_d;
    logic       armed_q,   armed_d;
    logic       cereal_q,  cereal_d;
    logic       status_q,  status_d;

    logic tick;
    logic frame_done;
    logic accept;

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .sysclk(sysclk),
        .rst   (rst),
        .clear (accept),
        .tick  (tick)
    );

    // The last stop tick counts as idle so an armed request can follow with no gap.
    assign frame_done = (state_q == STOP) && tick && (stop_idx_q == 1'(STOP_BITS - 1));
    assign accept     = start && armed_q && ((state_q == IDLE) || frame_done);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        cereal_d   = cereal_q;
        status_d   = status_q;

        case (state_q)
            IDLE: begin
                cereal_d = LINE_IDLE;
                status_d = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    cereal_d  = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            state_d  = PAR;
                            cereal_d = par_q;
                        end else begin
                            state_d    = STOP;
                            stop_idx_d = 1'b0;
                            cereal_d   = LINE_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        cereal_d  = shift_q[1];
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    cereal_d   = LINE_STOP;
                end
            end
            STOP: begin
                if (frame_done) begin
                    state_d  = IDLE;
                    status_d = 1'b1;
                end else if (tick) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cereal_d = LINE_IDLE;
                status_d = 1'b1;
            end
        endcase

        if (accept) begin
            state_d  = START;
            shift_d  = data;
            par_d    = parity_bit(data, PARITY);
            cereal_d = LINE_START;
            status_d = 1'b0;
        end

        if (accept) begin
            armed_d = 1'b0;
        end else if (!start) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            armed_q    <= 1'b0;
            cereal_q   <= LINE_IDLE;
            status_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            armed_q    <= armed_d;
            cereal_q   <= cereal_d;
            status_q   <= status_d;
        end
    end

    assign cereal = cereal_q;
    assign status = status_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: four instances cover no parity, odd, even and even+2 stop bits.
module tb_serial_tx;

    localparam int CPB = 4;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b0;
    logic [7:0] data   = 8'h00;
    logic       start0 = 1'b0;
    logic       start_o = 1'b0;
    logic       start_e = 1'b0;
    logic       start_s2 = 1'b0;

    logic cer0, st0, cer_o, st_o, cer_e, st_e, cer_s2, st_s2;

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    always #5 sysclk = ~sysclk;

    serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
        .sysclk(sysclk), .rst(rst), .data(data), .start(start0), .cereal(cer0), .status(st0));
    serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut_odd (
        .sysclk(sysclk), .rst(rst), .data(data), .start(start_o), .cereal(cer_o), .status(st_o));
    serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut_even (
        .sysclk(sysclk), .rst(rst), .data(data), .start(start_e), .cereal(cer_e), .status(st_e));
    serial_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut_s2 (
        .sysclk(sysclk), .rst(rst), .data(data), .start(start_s2), .cereal(cer_s2), .status(st_s2));

    function automatic logic get_cer(int d);
        case (d)
            0:       return cer0;
            1:       return cer_o;
            2:       return cer_e;
            default: return cer_s2;
        endcase
    endfunction

    function automatic logic get_st(int d);
        case (d)
            0:       return st0;
            1:       return st_o;
            2:       return st_e;
            default: return st_s2;
        endcase
    endfunction

    task automatic tick_n(int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic push_frame(logic [7:0] d, int par, int stops);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (par == 1) exp_q.push_back(~(^d));
        if (par == 2) exp_q.push_back(^d);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    // Waits for the frame to begin on the next edge, samples cereal mid-bit against the
    // scoreboard and measures how long status stays low.
    task automatic capture(int d, int exp_len, string name);
        int   offset;
        logic b;
        offset = 0;
        @(negedge sysclk);
        if (get_st(d) !== 1'b0) @(negedge sysclk);
        checks++;
        if (get_st(d) !== 1'b0) begin
            failures++;
            $display("FAIL %s_begin: status=%b required 0 on the request edge", name, get_st(d));
            exp_q.delete();
            return;
        end
        while (get_st(d) === 1'b0 && offset < 400) begin
            if ((offset % CPB) == 1 && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                checks++;
                if (get_cer(d) !== b) begin
                    failures++;
                    $display("FAIL %s_bit%0d: cereal=%b required %b", name, offset / CPB, get_cer(d), b);
                end
            end
            offset++;
            @(negedge sysclk);
        end
        checks++;
        if (offset != exp_len) begin
            failures++;
            $display("FAIL %s_len: status low %0d cycles required %0d", name, offset, exp_len);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_bits: %0d expected bits unsent required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic count_low(int d, int n, output int lows);
        lows = 0;
        repeat (n) begin
            @(negedge sysclk);
            if (get_st(d) !== 1'b1) lows++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (get_cer(d) !== 1'b1) begin
                failures++;
                $display("FAIL reset_cereal%0d: cereal=%b required 1", d, get_cer(d));
            end
            checks++;
            if (get_st(d) !== 1'b1) begin
                failures++;
                $display("FAIL reset_status%0d: status=%b required 1", d, get_st(d));
            end
        end
        tick_n(2);
        rst = 1'b0;
        tick_n(2);
    endtask

    task automatic test_basic();
        data = 8'h35;
        push_frame(8'h35, 0, 1);
        start0 = 1'b1;
        fork
            capture(0, 40, "basic");
            begin tick_n(1); start0 = 1'b0; end
        join
    endtask

    task automatic test_parity();
        data = 8'h35;
        push_frame(8'h35, 2, 1);
        start_e = 1'b1;
        fork
            capture(2, 44, "even");
            begin tick_n(1); start_e = 1'b0; end
        join
        push_frame(8'h35, 1, 1);
        start_o = 1'b1;
        fork
            capture(1, 44, "odd");
            begin tick_n(1); start_o = 1'b0; end
        join
        push_frame(8'h35, 2, 2);
        start_s2 = 1'b1;
        fork
            capture(3, 48, "stop2");
            begin tick_n(1); start_s2 = 1'b0; end
        join
    endtask

    task automatic test_held();
        int lows;
        tick_n(1);
        data = 8'h31;
        push_frame(8'h31, 0, 1);
        start0 = 1'b1;
        capture(0, 40, "held1");
        count_low(0, 150, lows);
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL held_extra: status low %0d cycles while start held, required 0", lows);
        end
        tick_n(1);
        start0 = 1'b0;
        tick_n(1);
        push_frame(8'h31, 0, 1);
        start0 = 1'b1;
        capture(0, 40, "held2");
        start0 = 1'b0;
        tick_n(2);
    endtask

    task automatic test_back_to_back();
        int lows;
        data = 8'h35;
        push_frame(8'h35, 0, 1);
        push_frame(8'h75, 0, 1);
        start0 = 1'b1;
        fork
            capture(0, 80, "b2b");
            begin
                tick_n(11);
                data   = 8'h75;
                start0 = 1'b0;
                tick_n(2);
                start0 = 1'b1;
                tick_n(3);
                start0 = 1'b0;
                tick_n(2);
                start0 = 1'b1;
            end
        join
        count_low(0, 50, lows);
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL b2b_third: status low %0d cycles after two frames, required 0", lows);
        end
        tick_n(1);
        start0 = 1'b0;
        tick_n(2);
    endtask

    task automatic test_reset_mid();
        int lows;
        data = 8'h35;
        start0 = 1'b1;
        tick_n(17);
        checks++;
        if (st0 !== 1'b0 || cer0 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pre: status=%b cereal=%b required 0 0 in data bit 3", st0, cer0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cer0 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_cereal: cereal=%b required 1", cer0);
        end
        checks++;
        if (st0 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_status: status=%b required 1", st0);
        end
        tick_n(2);
        rst = 1'b0;
        count_low(0, 60, lows);
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL rstmid_noframe: status low %0d cycles after release, required 0", lows);
        end
        tick_n(1);
        start0 = 1'b0;
        tick_n(1);
        push_frame(8'h35, 0, 1);
        start0 = 1'b1;
        capture(0, 40, "after_rst");
        start0 = 1'b0;
        tick_n(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_held();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Asynchronous serial (UART-style) transmitter that sits directly downstream of the keyboard stage. It accepts one 8-bit character per start request and shifts it out on a single line: one start bit, 8 data bits LSB first, optional parity, then one or two stop bits. It reports busy/idle back to the requester on `status`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 10417: sysclk cycles per serial bit (100 MHz / 9600 baud). Legal values are 2 or more.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values are 1 or 2.

Ports:
- `sysclk`  in  1: system clock. Single clock domain.
- `rst`  in  1: asynchronous, active-high reset.
- `data`  in  8: character to send. Sampled only on frame accept.
- `start`  in  1: level request from the upstream stage. May be held for many cycles.
- `cereal`  out  1: serial line. Idle level is high.
- `status`  out  1: 1 = idle and ready to accept; 0 = frame in progress.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- `armed` flag:
  - Resets to 0.
  - Set on any cycle where `start` is sampled low.
  - Cleared on frame accept.
- Frame accept happens when the state is IDLE, `start`=1 and `armed`=1, all on the same clock edge. On accept:
  - Latch `data` into the shift register.
  - Compute the parity bit from the latched data. Odd: XOR of the bits, inverted. Even: XOR of the bits.
  - Go to START and restart the bit counter.
- A held `start` therefore produces exactly one frame. A new frame requires `start` to drop low for at least one cycle first.
- `start` is ignored in every state except IDLE. `data` changes after accept have no effect on the frame in flight.
- Bit counter:
  - Counts 0..CLKS_PER_BIT-1.
  - The terminal count advances the bit.
  - Counter width is the ceiling of log2(CLKS_PER_BIT).
- Sequencing:
  - START drives 0 for one bit time.
  - DATA shifts out bits 0..7, tracked by a 3-bit index.
  - PAR is present only when PARITY≠0.
  - STOP drives 1 for STOP_BITS bit times, then returns to IDLE.
- `cereal` and `status` are driven directly from registers, never combinationally from inputs.

## Timing
- Reset values: `cereal`=1, `status`=1, state IDLE, `armed`=0, counters 0.
- Reset is asynchronous: outputs take their reset values immediately, including mid-frame. The aborted frame is not resumed.
- Accept edge is edge N. On edge N:
  - `status` falls to 0.
  - `cereal` falls to 0 (start bit).
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is F = CLKS_PER_BIT × (10 + (PARITY≠0) + (STOP_BITS−1)) cycles.
- `status` returns to 1 on edge N+F. `cereal` is already 1 at that point (stop level).
- Earliest next accept is edge N+F, provided `armed` was set by a low `start` during the frame. Back-to-back frames have no idle gap.
- When `start` is held through the end of a frame, `status` stays 1 and no frame starts until `start` has been low and then high again.
- When `rst` is deasserted while `start`=1, no frame is sent, because `armed`=0.

## Structure
- Shared package `serial_pkg` contains:
  - The state enum (IDLE, START, DATA, PAR, STOP).
  - Parity codes: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - Idle/start/stop line-level constants.
- One sub-module, `baud_gen`:
  - Parameter: CLKS_PER_BIT.
  - Inputs: `sysclk`, `rst`, `clear`.
  - Output: one-cycle `tick` at the end of each bit time.
  - `clear` is pulsed on frame accept so the first bit is full length.
- Top-level FSM, shift register, parity register and `armed` flag stay in `serial_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Basic frame: `data`=0x35, PARITY=0, STOP_BITS=1, pulse `start`.
  - `cereal` per 4-cycle bit: 0,1,0,1,0,1,1,0,0,1.
  - `status` is low for exactly 40 cycles.
- Parity: `data`=0x35.
  - PARITY=2: extra bit 0.
  - PARITY=1: extra bit 1.
  - In both cases `status` is low for 44 cycles.
  - With STOP_BITS=2 the stop high lasts 8 cycles and `status` is low for 48 cycles.
- Held request: `start` high for 200 cycles with `data`=0x31.
  - Exactly one frame is sent.
  - After `start` goes low for 1 cycle and high again, a second frame begins on that edge.
- Busy/data interference during a frame:
  - Toggle `start` and change `data` to 0x75 mid-frame.
  - The frame in flight completes with the original bits.
  - Because `start` was seen low during the frame, its high level at the end of the frame produces a back-to-back frame of 0x75 with no idle gap.
- Reset mid-frame: assert `rst` during data bit 3.
  - `cereal`=1 and `status`=1 within the same cycle.
  - After release with `start` held high, no frame is sent until `start` goes low then high.
